rr_merge_oehb: RTL

- Shares one opaque elastic buffer slot among NUM_INPUTS handshake producers.
- Selects among valid requesters with a round-robin arbiter and registers the winner's data and its index.
- Sits in front of a shared OEHB chain or another shared consumer, replacing a merge and a separate buffer.
- Latency is 1 cycle, like an OEHB. Ready is combinational from downstream.

---
 rtl/rr_merge_oehb_if.sv | 25 ++
 rtl/rr_merge_oehb.sv | 109 ++++++++++
 2 files changed

// File: rtl/rr_merge_oehb_if.sv
// Handshake bundle between NUM_INPUTS producers, the round-robin merge buffer and its consumer.
// The master side drives the requests and outs_ready. The slave side is the merge itself.
interface rr_merge_oehb_if #(
    parameter int DATA_TYPE  = 32,
    parameter int NUM_INPUTS = 4,
    parameter int INDEX_TYPE = 2
) ();
    logic [NUM_INPUTS*DATA_TYPE-1:0] ins;
    logic [NUM_INPUTS-1:0]           ins_valid;
    logic [NUM_INPUTS-1:0]           ins_ready;
    logic [DATA_TYPE-1:0]            outs;
    logic                            outs_valid;
    logic                            outs_ready;
    logic [INDEX_TYPE-1:0]           index;

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_valid, index
    );

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_valid, index
    );
endinterface

// File: rtl/rr_merge_oehb.sv
// Round-robin merge into a single opaque elastic buffer slot (1-cycle latency, ready passes through).
// Optional RR_MERGE_OEHB_PERF_CNT_EN adds saturating stall and per-channel grant counters.
module rr_merge_oehb #(
    parameter int DATA_TYPE  = 32,
    parameter int NUM_INPUTS = 4,
    parameter int INDEX_TYPE = 2
) (
    input logic            clk,
    input logic            rst,
    rr_merge_oehb_if.slave bus
`ifdef RR_MERGE_OEHB_PERF_CNT_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [NUM_INPUTS*16-1:0] grant_count
`endif
);
    localparam int PTR_W = $clog2(NUM_INPUTS);

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      grant;
    logic [PTR_W-1:0]      ptr_next;
    logic                  any_valid;
    logic                  accept;
    logic                  xfer;
    logic [NUM_INPUTS-1:0] ready;

    logic [DATA_TYPE-1:0]  data_p0;
    logic [INDEX_TYPE-1:0] index_p0;
    logic                  vld_p0;

    // The slot can take a word when it is empty or being drained this cycle.
    assign accept = !vld_p0 || bus.outs_ready;

    // Scan from the farthest offset down so the nearest valid requester after ptr wins.
    always_comb begin : grant_search
        int cand;
        cand      = 0;
        any_valid = 1'b0;
        grant     = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NUM_INPUTS;
            if (bus.ins_valid[cand]) begin
                any_valid = 1'b1;
                grant     = PTR_W'(cand);
            end
        end
    end

    assign ptr_next = (grant == PTR_W'(NUM_INPUTS - 1)) ? '0 : grant + PTR_W'(1);
    assign xfer     = rst && accept && any_valid;

    always_comb begin
        ready = '0;
        if (xfer) begin
            ready[grant] = 1'b1;
        end
    end

    // Stage p0: the single buffered word, its source index and valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0   <= 1'b0;
            data_p0  <= '0;
            index_p0 <= '0;
            ptr      <= '0;
        end else if (accept) begin
            vld_p0 <= any_valid;
            if (any_valid) begin
                data_p0  <= bus.ins[int'(grant)*DATA_TYPE +: DATA_TYPE];
                index_p0 <= INDEX_TYPE'(grant);
                ptr      <= ptr_next;
            end
        end
    end

    assign bus.ins_ready  = ready;
    assign bus.outs       = data_p0;
    assign bus.outs_valid = vld_p0;
    assign bus.index      = index_p0;

`ifdef RR_MERGE_OEHB_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [15:0] gcnt_q [NUM_INPUTS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (vld_p0 && !bus.outs_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!rst) begin
                gcnt_q[k] <= '0;
            end else if (xfer && (grant == PTR_W'(k)) && (gcnt_q[k] != 16'hFFFF)) begin
                gcnt_q[k] <= gcnt_q[k] + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_q;

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_pack
        assign grant_count[k*16 +: 16] = gcnt_q[k];
    end
`endif
endmodule
